// File: rtl/iq_if.sv
// Fetch-to-decode bundle for the instruction queue: fetch push side, decode pop side,
// and the occupancy/status signals fed back to fetch.
interface iq_if #(
  parameter int ADDR_W = 4
);
  // Push: any nonzero in_instr is a push; there is no fetch-side ready, and fetch backs off on iq_full.
  // Pop: the head entry transfers on a cycle where out_valid && out_ready. The head holds stable while
  // out_valid && !out_ready.
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [31:0]     out_pc;
  logic            out_compressed;
  logic            out_ready;
  logic            iq_full;
  logic [ADDR_W:0] count;
  logic            overflow;

  modport slave (
    input  in_instr, in_pc, out_ready,
    output out_valid, out_instr, out_pc, out_compressed, iq_full, count, overflow
  );

  modport master (
    output in_instr, in_pc, out_ready,
    input  out_valid, out_instr, out_pc, out_compressed, iq_full, count, overflow
  );
endinterface

// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch and decode. The head entry is shown combinationally.
// iq_full rises early so that fetches already in flight still fit.
module instr_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SLACK  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  iq_if.slave  bus
);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_C = (ADDR_W+1)'(DEPTH - SLACK);

  logic [31:0]      mem_instr [DEPTH];
  logic [31:0]      mem_pc    [DEPTH];
  logic [DEPTH-1:0] mem_comp;

  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0]   count;
  logic              overflow;

  logic push, pop, is_full, push_acc, drop, in_comp;
  logic [31:0] in_stored;

  always_comb begin
    push      = (bus.in_instr != 32'h0);
    pop       = (count != '0) && bus.out_ready;
    is_full   = (count == DEPTH_C);
    push_acc  = push && (!is_full || pop);
    drop      = push && is_full && !pop;
    in_comp   = (bus.in_instr[1:0] != 2'b11);
    in_stored = in_comp ? {16'h0, bus.in_instr[15:0]} : bus.in_instr;
  end

  // Storage has no reset: the contents are only observed through the count-gated out_valid.
  always_ff @(posedge clk) begin
    if (!flush && push_acc) begin
      mem_instr[tail] <= in_stored;
      mem_pc[tail]    <= bus.in_pc;
      mem_comp[tail]  <= in_comp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_acc) tail <= tail + 1'b1;
      if (pop)      head <= head + 1'b1;
      if (drop)     overflow <= 1'b1;
      case ({push_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid      = (count != '0);
  assign bus.out_instr      = mem_instr[head];
  assign bus.out_pc         = mem_pc[head];
  assign bus.out_compressed = mem_comp[head];
  assign bus.iq_full        = (count >= THRESH_C);
  assign bus.count          = count;
  assign bus.overflow       = overflow;
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a vector table for single-cycle behaviour, plus hand sequences
// for reset, fill/iq_full, wrap, full push+pop and overflow.
module tb_instr_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  iq_if #(.ADDR_W(4)) bus ();

  instr_queue #(.DEPTH(16), .ADDR_W(4), .SLACK(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        fl;
    logic        valid;
    logic [4:0]  cnt;
    logic        full;
    logic        ovf;
    logic        hchk;
    logic [31:0] hinstr;
    logic [31:0] hpc;
    logic        hcomp;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic r, input logic f);
    @(negedge clk);
    bus.in_instr  = i;
    bus.in_pc     = p;
    bus.out_ready = r;
    flush         = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_instr = 32'h0; bus.in_pc = 32'h0; bus.out_ready = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill16(input logic check_full);
    for (int i = 0; i < 16; i++) begin
      step(32'h13 | (i << 7), 32'(i * 4), 1'b0, 1'b0);
      exp_q.push_back(32'(i * 4));
      if (check_full) begin
        chk("fill_count", 64'(bus.count), 64'(i + 1));
        chk("fill_iq_full", 64'(bus.iq_full), 64'((i + 1) >= 14));
      end
    end
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk("drain_valid", 64'(bus.out_valid), 64'd1);
      chk("drain_pc", 64'(bus.out_pc), 64'(e));
      step(32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_empty_count", 64'(bus.count), 64'd0);
    chk("drain_empty_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.in_instr = 32'h0; bus.in_pc = 32'h0; bus.out_ready = 1'b0;

    //                instr          pc         rdy fl  val cnt full ovf hchk hinstr        hpc        hcomp
    vec[0] = '{32'hDEAD4501, 32'h100, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'h00004501, 32'h100, 1'b1};
    vec[1] = '{32'h00000013, 32'h104, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'h104, 1'b0};
    vec[2] = '{32'h00000000, 32'h0,   1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'h104, 1'b0};
    vec[3] = '{32'h12345678, 32'h108, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'h00005678, 32'h108, 1'b1};
    vec[4] = '{32'hABCD0003, 32'h10C, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 32'h00005678, 32'h108, 1'b1};
    vec[5] = '{32'h00000000, 32'h0,   1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'hABCD0003, 32'h10C, 1'b0};
    vec[6] = '{32'h00000017, 32'h110, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0};
    vec[7] = '{32'h00000000, 32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0};
    vec[8] = '{32'h00000033, 32'h200, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'h00000033, 32'h200, 1'b0};
    vec[9] = '{32'h00000000, 32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0};

    do_reset();
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_full", 64'(bus.iq_full), 64'd0);
    chk("reset_ovf", 64'(bus.overflow), 64'd0);

    // Reset asserted between clock edges partway through a fill
    for (int i = 0; i < 3; i++) step(32'h13, 32'(i * 4), 1'b0, 1'b0);
    chk("pre_reset_count", 64'(bus.count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(bus.out_valid), 64'd0);
    chk("async_reset_count", 64'(bus.count), 64'd0);
    chk("async_reset_ovf", 64'(bus.overflow), 64'd0);
    do_reset();

    // Fill to 16 with iq_full tracking, then push and pop together while full
    exp_q.delete();
    fill16(1'b1);
    chk("full_head_pc", 64'(bus.out_pc), 64'd0);
    step(32'h00000013, 32'h400, 1'b1, 1'b0);
    exp_q.pop_front();
    exp_q.push_back(32'h400);
    chk("fullpp_count", 64'(bus.count), 64'd16);
    chk("fullpp_ovf", 64'(bus.overflow), 64'd0);
    chk("fullpp_head_pc", 64'(bus.out_pc), 64'd4);
    drain();

    // Wrap: push 16, pop 10, push 8 -> pcs 40..60 then the new 8
    do_reset();
    exp_q.delete();
    fill16(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(32'h0, 32'h0, 1'b1, 1'b0);
      exp_q.pop_front();
    end
    for (int i = 0; i < 8; i++) begin
      step(32'h00000093, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
      exp_q.push_back(32'h1000 + 32'(i * 4));
    end
    chk("wrap_count", 64'(bus.count), 64'd14);
    chk("wrap_tail", 64'(dut.tail), 64'd8);
    drain();

    // Overflow: 17th push while full and not popping is dropped
    do_reset();
    exp_q.delete();
    fill16(1'b0);
    step(32'h00000013, 32'h500, 1'b0, 1'b0);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_count", 64'(bus.count), 64'd16);
    chk("ovf_head_pc", 64'(bus.out_pc), 64'd0);
    step(32'h00000013, 32'h504, 1'b1, 1'b1);
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_keeps_ovf", 64'(bus.overflow), 64'd1);
    do_reset();
    chk("reset_clears_ovf", 64'(bus.overflow), 64'd0);

    // Vector table
    for (int v = 0; v < 10; v++) begin
      step(vec[v].instr, vec[v].pc, vec[v].ready, vec[v].fl);
      chk($sformatf("v%0d_valid", v), 64'(bus.out_valid), 64'(vec[v].valid));
      chk($sformatf("v%0d_count", v), 64'(bus.count), 64'(vec[v].cnt));
      chk($sformatf("v%0d_full", v), 64'(bus.iq_full), 64'(vec[v].full));
      chk($sformatf("v%0d_ovf", v), 64'(bus.overflow), 64'(vec[v].ovf));
      if (vec[v].hchk) begin
        chk($sformatf("v%0d_instr", v), 64'(bus.out_instr), 64'(vec[v].hinstr));
        chk($sformatf("v%0d_pc", v), 64'(bus.out_pc), 64'(vec[v].hpc));
        chk($sformatf("v%0d_comp", v), 64'(bus.out_compressed), 64'(vec[v].hcomp));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
